// File: rtl/jt51_kon_pkg.sv
// Shared constants for the JT51 key-on sequencer: slot count,
// operator order within a channel and key-on mask bit mapping.
package jt51_kon_pkg;

    localparam int KON_SLOTS = 32;

    // Operator order inside the slot index {op, ch}
    localparam logic [1:0] OP_M1 = 2'd0;
    localparam logic [1:0] OP_M2 = 2'd1;
    localparam logic [1:0] OP_C1 = 2'd2;
    localparam logic [1:0] OP_C2 = 2'd3;

    // Key-on mask bit -> operator. Mask order is M1,C1,M2,C2,
    // which differs from the slot order M1,M2,C1,C2.
    function automatic logic [1:0] mask_bit_op(input logic [1:0] b);
        logic [1:0] op;
        case (b)
            2'd0:    op = OP_M1;
            2'd1:    op = OP_C1;
            2'd2:    op = OP_M2;
            default: op = OP_C2;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/jt51_kon_slotmap.sv
// Expands a {channel, operator mask} key-on write into slot vectors.
// Ports: i_ch/i_mask in; o_set = slots to key on, o_clr = all 4
// slots of the channel (cleared before o_set is applied).
module jt51_kon_slotmap
    import jt51_kon_pkg::*;
(
    input  logic [2:0]           i_ch,
    input  logic [3:0]           i_mask,
    output logic [KON_SLOTS-1:0] o_set,
    output logic [KON_SLOTS-1:0] o_clr
);

    always_comb begin
        logic [4:0] v_idx;
        o_set = '0;
        o_clr = '0;
        v_idx = '0;
        for (int b = 0; b < 4; b++) begin
            v_idx        = {mask_bit_op(2'(b)), i_ch};
            o_set[v_idx] = i_mask[b];
            o_clr[v_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/jt51_kon_seq.sv
// JT51 key-on sequencer: one pending key-on write applied atomically at
// frame start, serialised per slot as keyon_o/slot_o for the EG.
// Ports: clk, rst (sync, active-high), cen, zero (slot 0 marker),
// kon_we/kon_ch/kon_mask/kon_rdy (write handshake), csm_tick,
// keyon_o, slot_o. Optional composite sine mode: macro JT51_CSM_EN.
module jt51_kon_seq
    import jt51_kon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       zero,
    input  logic       kon_we,
    input  logic [2:0] kon_ch,
    input  logic [3:0] kon_mask,
    output logic       kon_rdy,
    input  logic       csm_tick,
    output logic       keyon_o,
    output logic [4:0] slot_o
);

    logic [KON_SLOTS-1:0] r_state;
    logic                 r_pend_v;
    logic [2:0]           r_pend_ch;
    logic [3:0]           r_pend_mask;
    logic [4:0]           r_slot;
    logic                 r_keyon;

    logic [KON_SLOTS-1:0] w_set;
    logic [KON_SLOTS-1:0] w_clr;
    logic [KON_SLOTS-1:0] w_state_nx;
    logic [4:0]           w_slot_nx;
    logic                 w_accept;
    logic                 w_fstart;
    logic                 w_apply;
    logic                 w_csm_on;

    jt51_kon_slotmap u_map (
        .i_ch   (r_pend_ch),
        .i_mask (r_pend_mask),
        .o_set  (w_set),
        .o_clr  (w_clr)
    );

    // A full pending slot blocks new writes, so accept and apply
    // can never coincide.
    assign w_accept = kon_we & ~r_pend_v;
    assign w_fstart = cen & zero;
    assign w_apply  = w_fstart & r_pend_v;

    // The new state is visible from slot 0 of the frame that starts
    // on the apply edge.
    assign w_state_nx = w_apply ? ((r_state & ~w_clr) | w_set)
                                : r_state;
    assign w_slot_nx  = zero ? 5'd0 : r_slot + 5'd1;

`ifdef JT51_CSM_EN
    logic r_csm_arm;
    logic r_csm_act;
    logic w_csm_start;
    logic w_frame_end;

    assign w_csm_start = w_fstart & r_csm_arm;
    // The CSM frame ends at the next frame boundary, whether that is
    // a zero marker or the natural 31->0 wrap.
    assign w_frame_end = cen & (zero | (r_slot == 5'd31));
    assign w_csm_on    = w_csm_start | (r_csm_act & ~w_frame_end);

    // Ticks while armed or active fold into the one event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csm_arm <= 1'b0;
            r_csm_act <= 1'b0;
        end else begin
            if (w_csm_start)
                r_csm_arm <= 1'b0;
            else if (csm_tick & ~r_csm_act)
                r_csm_arm <= 1'b1;
            if (w_csm_start)
                r_csm_act <= 1'b1;
            else if (w_frame_end)
                r_csm_act <= 1'b0;
        end
    end
`else
    logic w_unused_csm;
    assign w_unused_csm = csm_tick;
    assign w_csm_on     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= '0;
            r_pend_v    <= 1'b0;
            r_pend_ch   <= '0;
            r_pend_mask <= '0;
            r_slot      <= '0;
            r_keyon     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_v    <= 1'b1;
                r_pend_ch   <= kon_ch;
                r_pend_mask <= kon_mask;
            end else if (w_apply) begin
                r_pend_v <= 1'b0;
            end
            if (cen) begin
                r_state <= w_state_nx;
                r_slot  <= w_slot_nx;
                r_keyon <= w_csm_on | w_state_nx[w_slot_nx];
            end
        end
    end

    assign kon_rdy = ~r_pend_v;
    assign keyon_o = r_keyon;
    assign slot_o  = r_slot;

endmodule
